// File: rtl/clb_array.sv
// Reconfigurable carry-chain logic fabric: NUM_CLB blocks of CLB_W bits, each with its own op and
// carry-in source, loaded through a double-buffered serial configuration port.
module clb_array #(
  parameter int NUM_CLB = 4,
  parameter int CLB_W   = 2,
  parameter int CFG_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  input  logic [CFG_W-1:0]           cfg_data,
  output logic                       cfg_ready,
  output logic                       cfg_done,
  input  logic                       in_valid,
  input  logic [NUM_CLB*CLB_W-1:0]   in_a,
  input  logic [NUM_CLB*CLB_W-1:0]   in_b,
  input  logic                       c_in,
  output logic                       out_valid,
  output logic [NUM_CLB*CLB_W-1:0]   sum,
  output logic                       cout
);

  localparam int DW       = NUM_CLB * CLB_W;
  localparam int CFG_BITS = 4 * NUM_CLB;
  localparam int NWORDS   = (CFG_BITS + CFG_W - 1) / CFG_W;
  localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  localparam logic [1:0] CIN_ZERO  = 2'b00;
  localparam logic [1:0] CIN_CHAIN = 2'b01;
  localparam logic [1:0] CIN_ONE   = 2'b10;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CFG_BITS-1:0]   shadow_q, shadow_d;
  logic [CFG_BITS-1:0]   active_q, active_d;
  logic                  done_q, done_d;

  logic [CFG_BITS-1:0]   word_sel;
  logic [CFG_BITS-1:0]   word_bit;

  logic [DW-1:0]         sum_p0;
  logic                  cout_p0;
  logic [DW-1:0]         sum_p1;
  logic                  cout_p1;
  logic                  vld_p1;

  // Returns {carry_out, result} for one block.
  function automatic logic [CLB_W:0] clb_eval(
    input logic [1:0]       op,
    input logic [CLB_W-1:0] a,
    input logic [CLB_W-1:0] b,
    input logic             cin
  );
    logic [CLB_W:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b}  + {{CLB_W{1'b0}}, cin};
      OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + {{CLB_W{1'b0}}, cin};
      OP_AND:  r = {1'b0, a & b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  // Each assembled config bit knows which word and which bit of that word feeds it.
  for (genvar k = 0; k < CFG_BITS; k++) begin : g_word_map
    assign word_sel[k] = (cnt_q == CNT_W'(k / CFG_W));
    assign word_bit[k] = cfg_data[k % CFG_W];
  end

  assign cfg_ready = (state_q == LOAD);
  assign cfg_done  = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // A start pulse always wins over a coincident word; the final word goes straight into the swap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = done_q;
    if (cfg_start) begin
      state_d  = LOAD;
      cnt_d    = '0;
      shadow_d = '0;
    end else if (state_q == LOAD && cfg_valid) begin
      shadow_d = (shadow_q & ~word_sel) | (word_bit & word_sel);
      if (cnt_q == LAST_WORD) begin
        active_d = shadow_d;
        done_d   = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stage 0: combinational carry chain across all blocks using the active configuration.
  always_comb begin
    logic           carry;
    logic           cin_i;
    logic [3:0]     nib;
    logic [CLB_W:0] r;
    sum_p0 = '0;
    carry  = c_in;
    cin_i  = 1'b0;
    nib    = '0;
    r      = '0;
    for (int i = 0; i < NUM_CLB; i++) begin
      nib = 4'(active_q >> (4 * i));
      case (nib[3:2])
        CIN_ZERO:  cin_i = 1'b0;
        CIN_CHAIN: cin_i = carry;
        CIN_ONE:   cin_i = 1'b1;
        default:   cin_i = c_in;
      endcase
      r = clb_eval(nib[1:0], CLB_W'(in_a >> (i * CLB_W)), CLB_W'(in_b >> (i * CLB_W)), cin_i);
      sum_p0 = sum_p0 | (DW'(r[CLB_W-1:0]) << (i * CLB_W));
      carry  = r[CLB_W];
    end
    cout_p0 = carry;
  end

  // Stage 1: registered result; data holds when no operand is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid & done_q;
      if (in_valid && done_q) begin
        sum_p1  <= sum_p0;
        cout_p1 <= cout_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign sum       = sum_p1;
  assign cout      = cout_p1;

endmodule

// File: tb/tb_clb_array.sv
// Scoreboard bench for clb_array: a cycle-level protocol model predicts configuration state and
// pushes expected results; a negedge monitor pops and compares them.
module tb_clb_array;
  localparam int NUM_CLB  = 4;
  localparam int CLB_W    = 2;
  localparam int CFG_W    = 8;
  localparam int DW       = NUM_CLB * CLB_W;
  localparam int CFG_BITS = 4 * NUM_CLB;
  localparam int NWORDS   = (CFG_BITS + CFG_W - 1) / CFG_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [CFG_W-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic          cfg_done;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          c_in = 1'b0;
  logic          out_valid;
  logic [DW-1:0] sum;
  logic          cout;

  clb_array #(.NUM_CLB(NUM_CLB), .CLB_W(CLB_W), .CFG_W(CFG_W)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .c_in(c_in), .out_valid(out_valid), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int s;
    int c;
  } exp_t;
  exp_t exp_q[$];

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int m_load, m_cnt, m_shadow, m_active, m_done;
  int h_sum, h_cout;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int ref_eval(input int cfg, input int a, input int b, input int cin);
    int mask, carry, res, nib, op, sel, ci, ai, bi, s;
    mask  = (1 << CLB_W) - 1;
    carry = cin;
    res   = 0;
    for (int i = 0; i < NUM_CLB; i++) begin
      nib = (cfg >> (4 * i)) & 15;
      op  = nib & 3;
      sel = nib >> 2;
      ci  = (sel == 0) ? 0 : (sel == 1) ? carry : (sel == 2) ? 1 : cin;
      ai  = (a >> (i * CLB_W)) & mask;
      bi  = (b >> (i * CLB_W)) & mask;
      case (op)
        0: s = ai + bi + ci;
        1: s = ai + (mask - bi) + ci;
        2: s = ai & bi;
        default: s = ai ^ bi;
      endcase
      res   = res | ((s & mask) << (i * CLB_W));
      carry = (op < 2) ? (s >> CLB_W) : 0;
    end
    return res | (carry << DW);
  endfunction

  task automatic model_reset();
    m_load = 0; m_cnt = 0; m_shadow = 0; m_active = 0; m_done = 0;
    h_sum = 0; h_cout = 0;
    exp_q.delete();
  endtask

  // Predict what the coming edge does, then advance one clock and check the config outputs.
  task automatic tick();
    int r;
    if (reset) begin
      model_reset();
    end else begin
      if (in_valid && m_done != 0) begin
        r = ref_eval(m_active, int'(in_a), int'(in_b), int'(c_in));
        exp_q.push_back('{cyc_cnt + 1, r & ((1 << DW) - 1), r >> DW});
      end
      if (cfg_start) begin
        m_load = 1; m_cnt = 0; m_shadow = 0;
      end else if (m_load != 0 && cfg_valid) begin
        m_shadow = (m_shadow | (int'(cfg_data) << (m_cnt * CFG_W))) & ((1 << CFG_BITS) - 1);
        m_cnt++;
        if (m_cnt == NWORDS) begin
          m_active = m_shadow; m_done = 1; m_load = 0; m_cnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("cfg_ready", int'(cfg_ready), m_load);
    chk("cfg_done", int'(cfg_done), m_done);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_valid sum=%0h at t=%0t", sum, $time);
        end else begin
          e = exp_q.pop_front();
          chk("result_cycle", cyc_cnt, e.cyc);
          chk("sum", int'(sum), e.s);
          chk("cout", int'(cout), e.c);
          h_sum = e.s; h_cout = e.c;
        end
      end else begin
        chk("hold_sum", int'(sum), h_sum);
        chk("hold_cout", int'(cout), h_cout);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        checks++; failures++;
        $display("FAIL missing_out_valid expected_cycle=%0d now=%0d", exp_q[0].cyc, cyc_cnt);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic load(input logic [7:0] w0, input logic [7:0] w1);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    cfg_valid = 1'b1; cfg_data = w0; tick();
    cfg_data = w1; tick();
    cfg_valid = 1'b0;
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    in_valid = 1'b1; in_a = a; in_b = b; c_in = ci; tick();
    in_valid = 1'b0; tick();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("async_cfg_done", int'(cfg_done), 0);
    chk("async_cfg_ready", int'(cfg_ready), 0);
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_sum", int'(sum), 0);
    model_reset();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    tick(); tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_cout", int'(cout), 0);
    reset = 1'b0;
    tick(); tick();
    chk("noconfig_out_valid", int'(out_valid), 0);
    in_valid = 1'b0;

    load(8'h40, 8'h44);
    op(8'hF0, 8'h20, 1'b0);
    op(8'h7F, 8'h01, 1'b0);

    load(8'h59, 8'h55);
    op(8'h05, 8'h07, 1'b0);
    op(8'h07, 8'h05, 1'b0);

    load(8'h33, 8'h40);
    op(8'hA5, 8'h3C, 1'b0);
    load(8'h4C, 8'h44);
    op(8'h01, 8'h01, 1'b1);

    // Hot reload while operands stream every cycle.
    load(8'h40, 8'h44);
    in_valid = 1'b1; in_a = 8'h07; in_b = 8'h05; c_in = 1'b0;
    tick();
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'h59; tick();
    cfg_data = 8'h55; tick();
    cfg_valid = 1'b0; tick(); tick();
    in_valid = 1'b0; tick();

    // Start coincident with a word, then a restart after one word.
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h40; tick();
    cfg_start = 1'b0; cfg_data = 8'h40; tick();
    in_valid = 1'b1; in_a = 8'h07; in_b = 8'h05; tick();
    cfg_start = 1'b1; cfg_valid = 1'b0; tick();
    cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'h40; tick();
    cfg_data = 8'h44; tick();
    cfg_valid = 1'b0; tick();
    in_valid = 1'b0; tick();

    // Reset after one word.
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'h59; tick();
    cfg_valid = 1'b0;
    async_reset();
    tick();

    for (int i = 0; i < 400; i++) begin
      cfg_start = ($urandom_range(0, 24) == 0);
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_data  = 8'($urandom);
      in_valid  = $urandom_range(0, 3) != 0;
      in_a      = DW'($urandom);
      in_b      = DW'($urandom);
      c_in      = $urandom_range(0, 1) == 1;
      if (i == 250) async_reset();
      else tick();
    end
    cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clb_array.md
# clb_array

Parametrised configurable logic fabric: a chain of NUM_CLB identical CLB_W-bit logic blocks. Each block has a per-block operation and a per-block carry-in source. A serial configuration stream loads the operations and carry sources through a valid/ready port, and the stream is double-buffered so reconfiguration never disturbs the running datapath. The block is the next-generation compute core of the soft-FPGA: it supersedes the fixed 4×2-bit adder fabric with a registered, reconfigurable datapath.

## Interface
Parameters:
- NUM_CLB, 4, number of logic blocks in the carry chain (≥1)
- CLB_W, 2, data bits per block (≥1)
- CFG_W, 8, configuration word width (≥4)

Derived (localparam):
- DW = NUM_CLB*CLB_W
- CFG_BITS = 4*NUM_CLB
- NWORDS = ceil(CFG_BITS/CFG_W)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_start  in  1  pulse: begin (re)load of configuration
- cfg_valid  in  1  cfg_data is valid
- cfg_data  in  CFG_W  configuration word, LSB-first order
- cfg_ready  out  1  block accepts a config word this cycle
- cfg_done  out  1  an active configuration exists; datapath enabled
- in_valid  in  1  operands valid
- in_a  in  DW  operand A
- in_b  in  DW  operand B
- c_in  in  1  external carry input
- out_valid  out  1  sum/cout valid
- sum  out  DW  result
- cout  out  1  carry-out of block NUM_CLB-1

## Operation
- Per-block 4-bit config nibble; block i occupies bits [4i+3:4i] of the assembled CFG_BITS vector.
  - Nibble [1:0] op: 00 ADD (a+b+cin), 01 SUB (a+~b+cin), 10 AND, 11 XOR.
  - Nibble [3:2] cin_sel: 00 const 0, 01 chain (carry-out of block i-1; for block 0 this is c_in), 10 const 1, 11 c_in.
- Block i operates on bits [i*CLB_W +: CLB_W] of in_a and in_b.
- Carry-out: ADD/SUB produce the natural carry out of the CLB_W-bit sum. AND/XOR produce carry-out 0.
- Cin values are resolved combinationally along the chain within one cycle.
- Config word j fills assembled bits [j*CFG_W +: CFG_W]. Bits beyond CFG_BITS in the last word are ignored.
- Config FSM states:
  - IDLE: cfg_ready=0.
  - LOAD: cfg_ready=1, word counter 0..NWORDS-1.
- Config FSM transitions:
  - cfg_start in any state → LOAD, counter cleared, shadow register cleared.
  - In LOAD, each cfg_valid&cfg_ready accepts one word into the shadow register and increments the counter.
  - Acceptance of word NWORDS-1 → copy shadow (including the final word) into the active config, set cfg_done=1, → IDLE.
- cfg_start together with cfg_valid in the same cycle: start wins, the word is discarded, and the counter is 0 afterwards.
- cfg_start during LOAD restarts the load; the partial shadow is discarded.
- cfg_valid in IDLE is ignored.
- cfg_done stays 1 across a reload once set, and the old active config keeps operating until the atomic swap. Only reset clears cfg_done.
- Datapath: when in_valid&cfg_done, register sum, cout and out_valid=1. Otherwise out_valid=0 and sum/cout hold their last values.

## Timing
- Reset values: sum=0, cout=0, out_valid=0, cfg_ready=0, cfg_done=0, active config=0, shadow=0, state IDLE, counter 0.
- Datapath latency is 1 cycle: operands sampled at edge k appear at sum/cout/out_valid after edge k. Throughput is 1 result per cycle; there is no backpressure.
- cfg_ready rises the cycle after the edge that samples cfg_start.
- Last word accepted at edge k: the active config swaps at edge k and cfg_done is 1 after edge k. Operands sampled at edge k use the old config; operands sampled at edge k+1 use the new config.
- A full load takes NWORDS+1 cycles from cfg_start to cfg_done when cfg_valid is held high.
- Reset asserted mid-load or mid-operation: all state returns to reset values immediately (asynchronously). Any in-flight result is lost.

## Test plan
All scenarios use default parameters.
- Reset: hold reset, drive in_valid=1 → out_valid=0, cfg_done=0, sum=0x00. With in_valid=1 before any config → out_valid stays 0.
- 8-bit ADD chain: cfg_start, words 0x40, 0x44 → cfg_done=1. Then a=0xF0, b=0x20 → next cycle sum=0x10, cout=1. Then a=0x7F, b=0x01 → sum=0x80, cout=0.
- 8-bit SUB: load 0x59, 0x55. a=0x05, b=0x07 → sum=0xFE, cout=0. a=0x07, b=0x05 → sum=0x02, cout=1.
- Mixed mode: load 0x33, 0x40 (low nibble XOR, high nibble ADD). a=0xA5, b=0x3C → sum=0xD9, cout=0. External carry: load 0x4C, 0x44 with c_in=1, a=0x01, b=0x01 → sum=0x03.
- Hot reload: with ADD active, stream the SUB config while issuing a=0x07, b=0x05 every cycle. Results equal 0x0C until the last-word edge and 0x02 from the next sampled operand on. cfg_done never drops.
- Protocol edges:
  - cfg_start coincident with cfg_valid → word discarded, 2 further words still needed.
  - cfg_start after 1 word → restart.
  - reset after 1 word → cfg_done=0, cfg_ready=0.
